// File: rtl/raw8_axis_pack64_if.sv
// AXI4-Stream bundle shared by the RAW8 byte input and the 64-bit packed output.
// Byte-wide sinks have no use for tkeep, so the slave view leaves it out.
interface raw8_axis_pack64_if #(
   parameter int DATA_W = 8
) ();
   localparam int KEEP_W = (DATA_W + 7) / 8;

   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tlast;
   logic              tuser;

   modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
   modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/raw8_axis_pack64.sv
// Packs a RAW8 byte stream into 64-bit little-endian beats, checks frame length,
// and resynchronises on tuser after any framing error.
module raw8_axis_pack64 #(
   parameter int FRAME_BYTES = 512,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   raw8_axis_pack64_if.slave    s_axis,
   raw8_axis_pack64_if.master   m_axis,
   output logic                 frame_done,
   output logic                 len_err,
   output logic [CNT_W-1:0]     frame_cnt
);
   localparam int BC_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam logic [BC_W-1:0] LAST_CNT = BC_W'(FRAME_BYTES - 1);

   typedef enum logic {SYNC, ACTIVE} state_t;

   state_t          state;
   logic [2:0]      idx;
   logic [BC_W-1:0] byte_cnt;
   logic [63:0]     acc;
   logic            user_pend;

   logic [63:0]     data_reg;
   logic [7:0]      keep_reg;
   logic            valid_reg;
   logic            last_reg;
   logic            user_reg;

   logic            start;
   logic            drop;
   logic            at_end;
   logic            closes;
   logic            ends_frame;
   logic            acc_en;
   logic [2:0]      lane;
   logic [BC_W-1:0] cnt_eff;
   logic [63:0]     acc_next;

   // A tuser byte always restarts at lane 0, whether we were hunting or mid-frame.
   assign start      = s_axis.tuser;
   assign drop       = (state == SYNC) && !s_axis.tuser;
   assign lane       = start ? 3'd0 : idx;
   assign cnt_eff    = start ? '0 : byte_cnt;
   assign at_end     = (cnt_eff == LAST_CNT);
   assign ends_frame = s_axis.tlast || at_end;
   assign closes     = !drop && ((lane == 3'd7) || ends_frame);
   assign acc_en     = s_axis.tvalid && s_axis.tready;

   assign s_axis.tready = !(closes && valid_reg && !m_axis.tready);

   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign acc_next[8*gi +: 8] = (lane == 3'(gi)) ? s_axis.tdata
                                 : (start ? 8'h00 : acc[8*gi +: 8]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SYNC;
         idx        <= '0;
         byte_cnt   <= '0;
         acc        <= '0;
         user_pend  <= 1'b0;
         data_reg   <= '0;
         keep_reg   <= '0;
         valid_reg  <= 1'b0;
         last_reg   <= 1'b0;
         user_reg   <= 1'b0;
         frame_done <= 1'b0;
         len_err    <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_done <= 1'b0;
         len_err    <= 1'b0;
         if (valid_reg && m_axis.tready) begin
            valid_reg <= 1'b0;
         end
         if (acc_en && !drop) begin
            if (closes) begin
               valid_reg <= 1'b1;
               data_reg  <= acc_next;
               keep_reg  <= 8'hFF >> (3'd7 - lane);
               last_reg  <= ends_frame;
               user_reg  <= start || user_pend;
               acc       <= '0;
               idx       <= '0;
               user_pend <= 1'b0;
               if (ends_frame) begin
                  state    <= SYNC;
                  byte_cnt <= '0;
                  if (s_axis.tlast && at_end) begin
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + 1'b1;
                  end else begin
                     len_err <= 1'b1;
                  end
               end else begin
                  state    <= ACTIVE;
                  byte_cnt <= cnt_eff + 1'b1;
               end
            end else begin
               acc       <= acc_next;
               idx       <= lane + 3'd1;
               byte_cnt  <= cnt_eff + 1'b1;
               state     <= ACTIVE;
               user_pend <= start || user_pend;
            end
            // Restarting on tuser mid-frame abandons the partial frame.
            if (start && state == ACTIVE) begin
               len_err <= 1'b1;
            end
         end
      end
   end

   assign m_axis.tvalid = valid_reg;
   assign m_axis.tdata  = data_reg;
   assign m_axis.tkeep  = keep_reg;
   assign m_axis.tlast  = last_reg;
   assign m_axis.tuser  = user_reg;
endmodule

// File: tb/tb_raw8_axis_pack64.sv
// Directed, table-driven bench for raw8_axis_pack64: frame scenarios with
// hand-computed beat counts and status, plus restart and mid-frame reset sequences.
module tb_raw8_axis_pack64;
   localparam int FB = 512;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_done;
   logic        len_err;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   raw8_axis_pack64_if #(.DATA_W(8))  s_if ();
   raw8_axis_pack64_if #(.DATA_W(64)) m_if ();

   assign s_if.tkeep = 1'b1;

   raw8_axis_pack64 #(.FRAME_BYTES(FB), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_axis     (s_if),
      .m_axis     (m_if),
      .frame_done (frame_done),
      .len_err    (len_err),
      .frame_cnt  (frame_cnt)
   );

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
   } beat_t;

   typedef struct {
      int         n_bytes;
      int         last_at;
      int         garbage;
      int         bp;
      int         exp_beats;
      logic [7:0] exp_keep;
      int         exp_err;
      int         exp_done;
   } row_t;

   beat_t beats[$];
   int    checks = 0;
   int    passed = 0;
   int    err_cnt = 0;
   int    done_cnt = 0;
   int    stab_err = 0;
   int    rdy_err = 0;
   int    bp = 0;
   int    stall = 0;
   int    exp_cnt = 0;

   task automatic check(input bit ok, input string nm, input string got, input string want);
      checks++;
      if (ok) passed++;
      else $display("FAIL %s: got %s, expected %s", nm, got, want);
   endtask

   function automatic logic [63:0] exp_word(input int k);
      logic [63:0] w;
      for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(8*k + j);
      return w;
   endfunction

   function automatic logic [63:0] keep_mask(input logic [7:0] k);
      logic [63:0] m;
      for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{k[j]}};
      return m;
   endfunction

   // Monitor: beats, status pulses, output stability and s_tready legality.
   initial begin
      logic        stalled_prev;
      logic [63:0] pd;
      logic [7:0]  pk;
      logic        pl, pu;
      stalled_prev = 1'b0;
      pd = '0; pk = '0; pl = 1'b0; pu = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled_prev = 1'b0;
         end else begin
            if (stalled_prev && !(m_if.tvalid && m_if.tdata == pd && m_if.tkeep == pk &&
                                  m_if.tlast == pl && m_if.tuser == pu))
               stab_err++;
            stalled_prev = m_if.tvalid && !m_if.tready;
            pd = m_if.tdata; pk = m_if.tkeep; pl = m_if.tlast; pu = m_if.tuser;
            if (m_if.tvalid && m_if.tready)
               beats.push_back('{d: m_if.tdata, k: m_if.tkeep, l: m_if.tlast, u: m_if.tuser});
            if (!s_if.tready && !(m_if.tvalid && !m_if.tready)) rdy_err++;
            if (len_err) err_cnt++;
            if (frame_done) done_cnt++;
         end
      end
   end

   // Output-ready driver: always ready, or a 10-cycle stall at beat 5 then 50% toggling.
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp == 0) begin
            m_if.tready = 1'b1;
         end else if (beats.size() >= 5 && stall < 10) begin
            m_if.tready = 1'b0;
            stall++;
         end else if (stall >= 10) begin
            m_if.tready = ~m_if.tready;
         end else begin
            m_if.tready = 1'b1;
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] d, input logic l, input logic u);
      int w;
      bit ok;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.tuser  = u;
      w = 0;
      do begin
         @(negedge clk);
         ok = s_if.tready;
         @(posedge clk);
         #1;
         w++;
      end while (!ok && w < 200);
      if (!ok) check(1'b0, "s_tready_timeout", "no accept", "accept within 200 cycles");
      s_if.tvalid = 1'b0;
   endtask

   task automatic send_frame(input int n, input int last_at);
      for (int i = 0; i < n; i++) send_byte(8'(i), i == last_at, i == 0);
   endtask

   task automatic clear_obs();
      beats.delete();
      err_cnt = 0; done_cnt = 0; stab_err = 0; rdy_err = 0;
   endtask

   task automatic check_reset_vals(input string nm);
      check(m_if.tvalid == 0 && m_if.tdata == 0 && m_if.tkeep == 0 && m_if.tlast == 0 &&
            m_if.tuser == 0 && frame_done == 0 && len_err == 0 && frame_cnt == 0, nm,
            $sformatf("v=%0b d=%h k=%h l=%0b u=%0b fd=%0b le=%0b cnt=%0d", m_if.tvalid,
                      m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser, frame_done, len_err,
                      frame_cnt),
            "all zero");
   endtask

   task automatic run_row(input row_t r, input int id);
      int emit, nb, lim;
      logic [7:0]  ek;
      logic [63:0] m;
      clear_obs();
      bp = r.bp;
      stall = 0;
      for (int g = 0; g < r.garbage; g++) send_byte(8'hA5, 1'b0, 1'b0);
      send_frame(r.n_bytes, r.last_at);
      repeat (40) @(posedge clk);
      #1;
      bp = 0;
      exp_cnt += r.exp_done;
      emit = (r.last_at >= 0) ? r.last_at + 1 : r.n_bytes;
      if (emit > FB) emit = FB;
      nb = (emit + 7) / 8;
      check(beats.size() == r.exp_beats, $sformatf("row%0d_beats", id),
            $sformatf("%0d", beats.size()), $sformatf("%0d", r.exp_beats));
      lim = (beats.size() < nb) ? beats.size() : nb;
      for (int k = 0; k < lim; k++) begin
         ek = (k == nb - 1) ? r.exp_keep : 8'hFF;
         m  = keep_mask(ek);
         check(beats[k].k == ek && (beats[k].d & m) == (exp_word(k) & m) &&
               beats[k].l == (k == nb - 1) && beats[k].u == (k == 0),
               $sformatf("row%0d_beat%0d", id, k),
               $sformatf("d=%h k=%h l=%0b u=%0b", beats[k].d, beats[k].k, beats[k].l, beats[k].u),
               $sformatf("d=%h k=%h l=%0b u=%0b", exp_word(k) & m, ek, k == nb - 1, k == 0));
      end
      check(err_cnt == r.exp_err, $sformatf("row%0d_len_err", id),
            $sformatf("%0d", err_cnt), $sformatf("%0d", r.exp_err));
      check(done_cnt == r.exp_done, $sformatf("row%0d_frame_done", id),
            $sformatf("%0d", done_cnt), $sformatf("%0d", r.exp_done));
      check(frame_cnt == 16'(exp_cnt), $sformatf("row%0d_frame_cnt", id),
            $sformatf("%0d", frame_cnt), $sformatf("%0d", exp_cnt));
      check(stab_err == 0 && rdy_err == 0, $sformatf("row%0d_handshake", id),
            $sformatf("stab=%0d rdy=%0d", stab_err, rdy_err), "stab=0 rdy=0");
      $display("row %0d: bytes=%0d beats=%0d len_err=%0d frame_done=%0d frame_cnt=%0d",
               id, r.n_bytes, beats.size(), err_cnt, done_cnt, frame_cnt);
   endtask

   initial begin
      row_t rows[8];
      row_t nominal_g;
      rows[0] = '{n_bytes: 512, last_at: 511, garbage: 0, bp: 0, exp_beats: 64, exp_keep: 8'hFF, exp_err: 0, exp_done: 1};
      rows[1] = '{n_bytes: 512, last_at: 511, garbage: 0, bp: 1, exp_beats: 64, exp_keep: 8'hFF, exp_err: 0, exp_done: 1};
      rows[2] = '{n_bytes: 100, last_at: 99,  garbage: 0, bp: 0, exp_beats: 13, exp_keep: 8'h0F, exp_err: 1, exp_done: 0};
      rows[3] = '{n_bytes: 512, last_at: 511, garbage: 0, bp: 0, exp_beats: 64, exp_keep: 8'hFF, exp_err: 0, exp_done: 1};
      rows[4] = '{n_bytes: 520, last_at: -1,  garbage: 0, bp: 0, exp_beats: 64, exp_keep: 8'hFF, exp_err: 1, exp_done: 0};
      rows[5] = '{n_bytes: 512, last_at: 511, garbage: 0, bp: 0, exp_beats: 64, exp_keep: 8'hFF, exp_err: 0, exp_done: 1};
      rows[6] = '{n_bytes: 1,   last_at: 0,   garbage: 0, bp: 0, exp_beats: 1,  exp_keep: 8'h01, exp_err: 1, exp_done: 0};
      rows[7] = '{n_bytes: 512, last_at: 511, garbage: 5, bp: 0, exp_beats: 64, exp_keep: 8'hFF, exp_err: 0, exp_done: 1};
      nominal_g = rows[7];

      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset_values");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_row(rows[i], i);

      // tuser arriving mid-frame: two full beats escape, the partial third is discarded.
      clear_obs();
      send_frame(20, -1);
      send_frame(512, 511);
      repeat (40) @(posedge clk);
      #1;
      exp_cnt += 1;
      check(beats.size() == 66, "restart_beats", $sformatf("%0d", beats.size()), "66");
      if (beats.size() == 66) begin
         check(beats[0].d == 64'h0706050403020100 && beats[0].u && !beats[0].l, "restart_beat0",
               $sformatf("d=%h u=%0b l=%0b", beats[0].d, beats[0].u, beats[0].l),
               "d=0706050403020100 u=1 l=0");
         check(beats[1].d == 64'h0F0E0D0C0B0A0908 && !beats[1].u && !beats[1].l, "restart_beat1",
               $sformatf("d=%h u=%0b l=%0b", beats[1].d, beats[1].u, beats[1].l),
               "d=0f0e0d0c0b0a0908 u=0 l=0");
         check(beats[2].d == exp_word(0) && beats[2].u && beats[2].k == 8'hFF, "restart_newframe",
               $sformatf("d=%h u=%0b k=%h", beats[2].d, beats[2].u, beats[2].k),
               $sformatf("d=%h u=1 k=ff", exp_word(0)));
         check(beats[65].d == 64'hFFFEFDFCFBFAF9F8 && beats[65].l && !beats[65].u, "restart_last",
               $sformatf("d=%h l=%0b u=%0b", beats[65].d, beats[65].l, beats[65].u),
               "d=fffefdfcfbfaf9f8 l=1 u=0");
      end
      check(err_cnt == 1 && done_cnt == 1 && frame_cnt == 16'(exp_cnt), "restart_status",
            $sformatf("err=%0d done=%0d cnt=%0d", err_cnt, done_cnt, frame_cnt),
            $sformatf("err=1 done=1 cnt=%0d", exp_cnt));
      $display("restart: beats=%0d len_err=%0d frame_done=%0d frame_cnt=%0d",
               beats.size(), err_cnt, done_cnt, frame_cnt);

      // Reset at byte 300 of a frame, held 2 cycles, then garbage plus a nominal frame.
      send_frame(300, -1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("midreset_values");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_cnt = 0;
      $display("mid-frame reset applied");
      run_row(nominal_g, 8);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
